// File: rtl/stim_ctrl_pkg.sv
// rtl/stim_ctrl_pkg.sv - state encoding, default timing constants and counter sizing for stim_controller
package stim_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STIM    = 2'd1,
    S_REFRACT = 2'd2
  } state_t;

  localparam int unsigned DEF_PERSIST    = 4;
  localparam int unsigned DEF_PULSE_ON   = 8;
  localparam int unsigned DEF_PULSE_OFF  = 8;
  localparam int unsigned DEF_NUM_PULSES = 5;
  localparam int unsigned DEF_REFRACT    = 1000;
  localparam int unsigned DEF_CNT_W      = 16;

  // A counter running 0..n-1 needs $clog2(n) bits, but never fewer than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stim_pulse_gen.sv
// rtl/stim_pulse_gen.sv - ON/OFF pulse train generator; pulse is registered, done marks the last OFF cycle
module stim_pulse_gen
  import stim_ctrl_pkg::*;
#(
  parameter int unsigned PULSE_ON   = DEF_PULSE_ON,
  parameter int unsigned PULSE_OFF  = DEF_PULSE_OFF,
  parameter int unsigned NUM_PULSES = DEF_NUM_PULSES
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic pulse,
  output logic done
);

  localparam int unsigned PH_MAX = (PULSE_ON > PULSE_OFF) ? PULSE_ON : PULSE_OFF;
  localparam int unsigned PH_W   = cnt_w(PH_MAX);
  localparam int unsigned NP_W   = cnt_w(NUM_PULSES);

  logic            active;
  logic [PH_W-1:0] phase_cnt;
  logic [NP_W-1:0] pulse_cnt;
  logic            on_end;
  logic            off_end;
  logic            last_pulse;

  assign on_end     = pulse && (phase_cnt == PH_W'(PULSE_ON - 1));
  assign off_end    = active && !pulse && (phase_cnt == PH_W'(PULSE_OFF - 1));
  assign last_pulse = (pulse_cnt == NP_W'(NUM_PULSES - 1));
  assign done       = off_end && last_pulse;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      active    <= 1'b0;
      pulse     <= 1'b0;
      phase_cnt <= '0;
      pulse_cnt <= '0;
    end else if (start) begin
      active    <= 1'b1;
      pulse     <= 1'b1;
      phase_cnt <= '0;
      pulse_cnt <= '0;
    end else if (active) begin
      if (pulse) begin
        if (on_end) begin
          pulse     <= 1'b0;
          phase_cnt <= '0;
        end else begin
          phase_cnt <= phase_cnt + 1'b1;
        end
      end else if (off_end) begin
        phase_cnt <= '0;
        if (last_pulse) begin
          active <= 1'b0;
        end else begin
          pulse_cnt <= pulse_cnt + 1'b1;
          pulse     <= 1'b1;
        end
      end else begin
        phase_cnt <= phase_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stim_controller.sv
// rtl/stim_controller.sv - persistence-gated stimulation FSM (IDLE/STIM/REFRACT)
// Optional train counter output event_cnt enabled by macro STIM_CTRL_EVENT_CNT_EN.
module stim_controller
  import stim_ctrl_pkg::*;
#(
  parameter int unsigned PERSIST    = DEF_PERSIST,
  parameter int unsigned PULSE_ON   = DEF_PULSE_ON,
  parameter int unsigned PULSE_OFF  = DEF_PULSE_OFF,
  parameter int unsigned NUM_PULSES = DEF_NUM_PULSES,
  parameter int unsigned REFRACT    = DEF_REFRACT,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             detect,
  input  logic             sample_valid,
  output logic             stim_out,
  output logic             busy,
  output logic [1:0]       state_o
`ifdef STIM_CTRL_EVENT_CNT_EN
  ,
  output logic [CNT_W-1:0] event_cnt
`endif
);

  localparam int unsigned PS_W = cnt_w(PERSIST);
  localparam int unsigned RF_W = cnt_w(REFRACT);

  state_t          state;
  logic [PS_W-1:0] persist_cnt;
  logic [RF_W-1:0] ref_cnt;
  logic            accepted;
  logic            trigger;
  logic            train_done;

  // en is active-low: a high level disables the block and aborts any train.
  assign accepted = sample_valid && !en;
  assign trigger  = (state == S_IDLE) && accepted && detect &&
                    (persist_cnt == PS_W'(PERSIST - 1));
  assign busy     = (state != S_IDLE);
  assign state_o  = state;

  stim_pulse_gen #(
    .PULSE_ON   (PULSE_ON),
    .PULSE_OFF  (PULSE_OFF),
    .NUM_PULSES (NUM_PULSES)
  ) u_pulse_gen (
    .clk   (clk),
    .rst   (rst),
    .start (trigger),
    .abort (en),
    .pulse (stim_out),
    .done  (train_done)
  );

  always_ff @(posedge clk) begin
    if (rst || en) begin
      state       <= S_IDLE;
      persist_cnt <= '0;
      ref_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (trigger) begin
            state       <= S_STIM;
            persist_cnt <= '0;
          end else if (accepted) begin
            persist_cnt <= detect ? persist_cnt + 1'b1 : '0;
          end
        end
        S_STIM: begin
          if (train_done) begin
            state   <= S_REFRACT;
            ref_cnt <= '0;
          end
        end
        S_REFRACT: begin
          if (ref_cnt == RF_W'(REFRACT - 1)) begin
            state       <= S_IDLE;
            ref_cnt     <= '0;
            persist_cnt <= '0;
          end else begin
            ref_cnt <= ref_cnt + 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          persist_cnt <= '0;
          ref_cnt     <= '0;
        end
      endcase
    end
  end

`ifdef STIM_CTRL_EVENT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      event_cnt <= '0;
    end else if (trigger && (event_cnt != {CNT_W{1'b1}})) begin
      event_cnt <= event_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stim_controller.sv
// tb/tb_stim_controller.sv - directed self-checking bench for stim_controller
module tb_stim_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       detect = 1'b0;
  logic       sample_valid = 1'b0;
  logic       stim_out;
  logic       busy;
  logic [1:0] state_o;
`ifdef STIM_CTRL_EVENT_CNT_EN
  logic [1:0] event_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  stim_controller #(
    .PERSIST    (4),
    .PULSE_ON   (2),
    .PULSE_OFF  (3),
    .NUM_PULSES (3),
    .REFRACT    (10),
    .CNT_W      (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .detect       (detect),
    .sample_valid (sample_valid),
    .stim_out     (stim_out),
    .busy         (busy),
    .state_o      (state_o)
`ifdef STIM_CTRL_EVENT_CNT_EN
    ,
    .event_cnt    (event_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic d);
    sample_valid = 1'b1;
    detect = d;
    tick();
    sample_valid = 1'b0;
    detect = 1'b0;
  endtask

  task automatic trigger_train();
    for (int i = 0; i < 4; i++) send(1'b1);
  endtask

  task automatic abort_via_en();
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; detect = 1'b1; sample_valid = 1'b1;
    tick(); tick();
    vectors++; if (stim_out !== 1'b0) begin miscompares++; $display("FAIL reset_stim: got %b expected 0", stim_out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (state_o !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state_o); end
`ifdef STIM_CTRL_EVENT_CNT_EN
    vectors++; if (event_cnt !== 2'd0) begin miscompares++; $display("FAIL reset_event_cnt: got %0d expected 0", event_cnt); end
`endif
    rst = 1'b0; detect = 1'b0; sample_valid = 1'b0;
    tick();
  endtask

  task automatic test_single_train();
    int busy_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      send(1'b1);
      vectors++; if (state_o !== 2'd0) begin miscompares++; $display("FAIL single_pre_state i=%0d: got %0d expected 0", i, state_o); end
    end
    send(1'b1);
    for (int k = 0; k <= 25; k++) begin
      logic       es;
      logic [1:0] est;
      es  = (k < 15) && ((k % 5) < 2);
      est = (k < 15) ? 2'd1 : (k < 25) ? 2'd2 : 2'd0;
      if (busy === 1'b1) busy_cycles++;
      vectors++; if (stim_out !== es) begin miscompares++; $display("FAIL single_stim k=%0d: got %b expected %b", k, stim_out, es); end
      vectors++; if (state_o !== est) begin miscompares++; $display("FAIL single_state k=%0d: got %0d expected %0d", k, state_o, est); end
      if (k < 25) tick();
    end
    vectors++; if (busy_cycles != 25) begin miscompares++; $display("FAIL single_busy_cycles: got %0d expected 25", busy_cycles); end
  endtask

  task automatic test_persist_break();
    logic pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      logic [1:0] est;
      send(pat[i]);
      est = (i == 7) ? 2'd1 : 2'd0;
      vectors++; if (state_o !== est) begin miscompares++; $display("FAIL break_state i=%0d: got %0d expected %0d", i, state_o, est); end
      if (i >= 4 && i <= 6) begin
        tick();
        vectors++; if (state_o !== 2'd0) begin miscompares++; $display("FAIL break_hold i=%0d: got %0d expected 0", i, state_o); end
      end
    end
    vectors++; if (stim_out !== 1'b1) begin miscompares++; $display("FAIL break_stim: got %b expected 1", stim_out); end
    abort_via_en();
    en = 1'b1; sample_valid = 1'b1; detect = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    en = 1'b0; sample_valid = 1'b0; detect = 1'b0;
    vectors++; if (state_o !== 2'd0) begin miscompares++; $display("FAIL break_en_ignored: got %0d expected 0", state_o); end
    send(1'b1);
    vectors++; if (state_o !== 2'd0) begin miscompares++; $display("FAIL break_no_preload: got %0d expected 0", state_o); end
    send(1'b0);
  endtask

  task automatic test_back_to_back();
    sample_valid = 1'b1; detect = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    for (int k = 0; k <= 29; k++) begin
      logic [1:0] est;
      est = (k < 15) ? 2'd1 : (k < 25) ? 2'd2 : (k < 29) ? 2'd0 : 2'd1;
      vectors++; if (state_o !== est) begin miscompares++; $display("FAIL b2b_state k=%0d: got %0d expected %0d", k, state_o, est); end
      if (k < 29) tick();
    end
    vectors++; if (stim_out !== 1'b1) begin miscompares++; $display("FAIL b2b_stim: got %b expected 1", stim_out); end
    sample_valid = 1'b0; detect = 1'b0;
    abort_via_en();
  endtask

  task automatic test_enable_abort();
    trigger_train();
    for (int i = 0; i < 5; i++) tick();
    vectors++; if (stim_out !== 1'b1) begin miscompares++; $display("FAIL en_second_pulse: got %b expected 1", stim_out); end
    en = 1'b1;
    tick();
    vectors++; if (stim_out !== 1'b0) begin miscompares++; $display("FAIL en_stim: got %b expected 0", stim_out); end
    vectors++; if (state_o !== 2'd0) begin miscompares++; $display("FAIL en_state: got %0d expected 0", state_o); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL en_busy: got %b expected 0", busy); end
    en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      vectors++; if (stim_out !== 1'b0) begin miscompares++; $display("FAIL en_no_more_pulses i=%0d: got %b expected 0", i, stim_out); end
    end
  endtask

  task automatic test_reset_refract();
    trigger_train();
    for (int i = 0; i < 20; i++) tick();
    vectors++; if (state_o !== 2'd2) begin miscompares++; $display("FAIL rref_in_refract: got %0d expected 2", state_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (state_o !== 2'd0) begin miscompares++; $display("FAIL rref_state: got %0d expected 0", state_o); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rref_busy: got %b expected 0", busy); end
    vectors++; if (stim_out !== 1'b0) begin miscompares++; $display("FAIL rref_stim: got %b expected 0", stim_out); end
    for (int i = 0; i < 3; i++) begin
      send(1'b1);
      vectors++; if (state_o !== 2'd0) begin miscompares++; $display("FAIL rref_fresh i=%0d: got %0d expected 0", i, state_o); end
    end
    send(1'b1);
    vectors++; if (stim_out !== 1'b1) begin miscompares++; $display("FAIL rref_retrigger: got %b expected 1", stim_out); end
    abort_via_en();
  endtask

`ifdef STIM_CTRL_EVENT_CNT_EN
  task automatic test_event_cnt();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      trigger_train();
      vectors++; if (event_cnt !== exp_cnt[t]) begin miscompares++; $display("FAIL event_cnt t=%0d: got %0d expected %0d", t, event_cnt, exp_cnt[t]); end
      abort_via_en();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_train();
    test_persist_break();
    test_back_to_back();
    test_enable_abort();
    test_reset_refract();
`ifdef STIM_CTRL_EVENT_CNT_EN
    test_event_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
